izh_neur_update_sched: RTL and testbench

// - Sequences read-modify-write of Izhikevich neuron state in the neuron SRAM; shares the update datapath
//   (effective-threshold/leak logic) between synaptic-event updates and time-reference (tref) sweeps.
// - A tref tick triggers a sweep over all neurons with event_tref asserted; synaptic events interleave between sweep steps.

---
 rtl/izh_sched_pkg.sv | 21 ++
 rtl/izh_sched_arb.sv | 38 +++
 rtl/izh_neur_update_sched.sv | 151 +++++++++++++++
 tb/tb_izh_neur_update_sched.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/izh_sched_pkg.sv
// Shared types and defaults for the Izhikevich neuron update scheduler.
package izh_sched_pkg;

  localparam int N_NEUR_DEF      = 256;
  localparam int AW_DEF          = 8;
  localparam int MAX_EVT_RUN_DEF = 4;
  // Width of the event-run counter; it saturates at 15.
  localparam int RUN_W           = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  typedef enum logic {
    UPD_SYN  = 1'b0,
    UPD_TREF = 1'b1
  } upd_kind_t;

endpackage

// File: rtl/izh_sched_arb.sv
// Update arbiter: chooses between a synaptic-event update and a tref sweep
// step whenever the FSM may start a new update, and tracks how many event
// updates have run back-to-back so a pending sweep cannot be starved.
module izh_sched_arb
  import izh_sched_pkg::*;
#(
  parameter int MAX_EVT_RUN = MAX_EVT_RUN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             decide,
  input  logic             evt_req,
  input  logic             sweep_active,
  output logic             sel_evt,
  output logic             sel_tref,
  output logic [RUN_W-1:0] evt_run
);

  // Events win unless a sweep is active and the run budget is used up.
  always_comb begin
    sel_evt  = evt_req & (~sweep_active | (evt_run < RUN_W'(MAX_EVT_RUN)));
    sel_tref = ~sel_evt & sweep_active;
  end

  // Run counter: saturating increment per event, cleared by anything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_run <= '0;
    end else if (decide) begin
      if (sel_evt) begin
        if (evt_run != {RUN_W{1'b1}}) evt_run <= evt_run + RUN_W'(1);
      end else begin
        evt_run <= '0;
      end
    end
  end

endmodule

// File: rtl/izh_neur_update_sched.sv
// Izhikevich neuron update scheduler: serialises read-modify-write updates
// of the neuron SRAM for synaptic events and time-reference sweeps.
// Each update is one RD cycle followed by one WR cycle to the same address.
// Optional feature macro: IZH_SCHED_SKIP_DISABLED_EN -- skip the write-back
// of tref steps for neurons whose disable flag reads back as 1.
module izh_neur_update_sched
  import izh_sched_pkg::*;
#(
  parameter int N_NEUR      = N_NEUR_DEF,
  parameter int AW          = AW_DEF,
  parameter int MAX_EVT_RUN = MAX_EVT_RUN_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          TREF_TICK,
  input  logic          EVT_REQ,
  input  logic [AW-1:0] EVT_NEUR,
  output logic          EVT_ACK,
  output logic          NEUR_CS,
  output logic          NEUR_WE,
  output logic [AW-1:0] NEUR_ADDR,
  input  logic          NEUR_RDATA_MSB,
  output logic          DP_EVENT_TREF,
  output logic          DP_EVENT_SYN,
  output logic          SWEEP_BUSY,
  output logic          TREF_OVERRUN,
  output logic [1:0]    FSM_STATE
);

  // Handshake: EVT_REQ is a level held by the requester until EVT_ACK, which
  // pulses for one cycle in the WR cycle of the event's update. EVT_NEUR must
  // be stable while EVT_REQ is high; it is captured when the RD cycle starts.

  state_t          state, state_nxt;
  upd_kind_t       kind_q;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   sweep_ptr;
  logic [AW-1:0]   ptr_inc;
  logic [AW-1:0]   tref_addr;
  logic            sweep_active;
  logic            sweep_pend;
  logic            overrun_q;
  logic            decide;
  logic            tref_wr;
  logic            last_wr;
  logic            tick_to_pend;
  logic            tick_drop;
  logic            pend_eff;
  logic            active_dec;
  logic            sel_evt;
  logic            sel_tref;
  logic            skip_wr;
  logic [RUN_W-1:0] evt_run;

  // Sweep bookkeeping seen by the arbiter. On the last-neuron WR the arbiter
  // must see the post-wrap sweep state, otherwise it would start a step of a
  // sweep that is just ending.
  always_comb begin
    decide       = (state == ST_IDLE) | (state == ST_WR);
    tref_wr      = (state == ST_WR) & (kind_q == UPD_TREF);
    last_wr      = tref_wr & (sweep_ptr == AW'(N_NEUR - 1));
    tick_to_pend = TREF_TICK & sweep_active & ~sweep_pend;
    tick_drop    = TREF_TICK & sweep_active & sweep_pend;
    pend_eff     = sweep_pend | tick_to_pend;
    active_dec   = last_wr ? pend_eff : sweep_active;
    ptr_inc      = last_wr ? '0 : sweep_ptr + AW'(1);
    tref_addr    = tref_wr ? ptr_inc : sweep_ptr;
  end

  izh_sched_arb #(
    .MAX_EVT_RUN (MAX_EVT_RUN)
  ) u_arb (
    .clk          (CLK),
    .rst          (RST),
    .decide       (decide),
    .evt_req      (EVT_REQ),
    .sweep_active (active_dec),
    .sel_evt      (sel_evt),
    .sel_tref     (sel_tref),
    .evt_run      (evt_run)
  );

  // FSM next state: IDLE/WR may launch a new RD; RD always proceeds to WR.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_WR: state_nxt = (sel_evt | sel_tref) ? ST_RD : ST_IDLE;
      ST_RD:          state_nxt = ST_WR;
      default:        state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register plus the address/kind latched at RD entry.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= ST_IDLE;
      kind_q <= UPD_SYN;
      addr_q <= '0;
    end else begin
      state <= state_nxt;
      if (decide & (sel_evt | sel_tref)) begin
        kind_q <= sel_evt ? UPD_SYN : UPD_TREF;
        addr_q <= sel_evt ? EVT_NEUR : tref_addr;
      end
    end
  end

  // Sweep pointer, active/pending flags and the sticky overrun flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sweep_ptr    <= '0;
      sweep_active <= 1'b0;
      sweep_pend   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (tref_wr) sweep_ptr <= ptr_inc;
      if (last_wr) begin
        sweep_active <= pend_eff;
        sweep_pend   <= 1'b0;
      end else if (TREF_TICK & ~sweep_active) begin
        sweep_active <= 1'b1;
      end else if (tick_to_pend) begin
        sweep_pend <= 1'b1;
      end
      if (tick_drop) overrun_q <= 1'b1;
    end
  end

`ifdef IZH_SCHED_SKIP_DISABLED_EN
  // Disable flag from the RD is valid in the WR cycle; gate that write.
  assign skip_wr = (state == ST_WR) & (kind_q == UPD_TREF) & NEUR_RDATA_MSB;
`else
  logic unused_rdata;
  assign skip_wr      = 1'b0;
  assign unused_rdata = NEUR_RDATA_MSB;
`endif

  // SRAM port and datapath qualifiers.
  always_comb begin
    NEUR_CS       = (state != ST_IDLE) & ~skip_wr;
    NEUR_WE       = (state == ST_WR) & ~skip_wr;
    NEUR_ADDR     = addr_q;
    DP_EVENT_TREF = (state != ST_IDLE) & (kind_q == UPD_TREF);
    DP_EVENT_SYN  = (state != ST_IDLE) & (kind_q == UPD_SYN);
    EVT_ACK       = (state == ST_WR) & (kind_q == UPD_SYN);
    SWEEP_BUSY    = sweep_active;
    TREF_OVERRUN  = overrun_q;
    FSM_STATE     = state;
  end

endmodule

// File: tb/tb_izh_neur_update_sched.sv
// Directed bench for izh_neur_update_sched.
module tb_izh_neur_update_sched;

  logic       CLK = 1'b0;
  logic       RST;
  logic       TREF_TICK;
  logic       EVT_REQ;
  logic [7:0] EVT_NEUR;
  logic       EVT_ACK;
  logic       NEUR_CS;
  logic       NEUR_WE;
  logic [7:0] NEUR_ADDR;
  logic       NEUR_RDATA_MSB;
  logic       DP_EVENT_TREF;
  logic       DP_EVENT_SYN;
  logic       SWEEP_BUSY;
  logic       TREF_OVERRUN;
  logic [1:0] FSM_STATE;

  int n_tests = 0;
  int n_fail  = 0;

  izh_neur_update_sched dut (
    .CLK            (CLK),
    .RST            (RST),
    .TREF_TICK      (TREF_TICK),
    .EVT_REQ        (EVT_REQ),
    .EVT_NEUR       (EVT_NEUR),
    .EVT_ACK        (EVT_ACK),
    .NEUR_CS        (NEUR_CS),
    .NEUR_WE        (NEUR_WE),
    .NEUR_ADDR      (NEUR_ADDR),
    .NEUR_RDATA_MSB (NEUR_RDATA_MSB),
    .DP_EVENT_TREF  (DP_EVENT_TREF),
    .DP_EVENT_SYN   (DP_EVENT_SYN),
    .SWEEP_BUSY     (SWEEP_BUSY),
    .TREF_OVERRUN   (TREF_OVERRUN),
    .FSM_STATE      (FSM_STATE)
  );

  // clock
  always #5 CLK = ~CLK;

  wire [31:0] obs = {18'b0, NEUR_CS, NEUR_WE, DP_EVENT_TREF, DP_EVENT_SYN,
                     EVT_ACK, SWEEP_BUSY, NEUR_ADDR};

  function automatic logic [31:0] mk(input bit cs, input bit we, input bit tref,
                                     input bit syn, input bit ack, input bit busy,
                                     input int addr);
    logic [7:0] a;
    a = addr[7:0];
    return {18'b0, cs, we, tref, syn, ack, busy, a};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // One full update: RD cycle then WR cycle, ending one step after the WR.
  task automatic exp_upd(input string tag, input bit tref, input int addr, input bit busy);
    chk({tag, "_rd"}, obs, mk(1, 0, tref, !tref, 0, busy, addr));
    step();
    chk({tag, "_wr"}, obs, mk(1, 1, tref, !tref, !tref, busy, addr));
    step();
  endtask

  initial begin
    bit found;
    RST = 1'b1; TREF_TICK = 1'b0; EVT_REQ = 1'b0; EVT_NEUR = 8'h00; NEUR_RDATA_MSB = 1'b0;

    // ---- reset and idle
    #1;
    chk("reset_outs", obs, mk(0, 0, 0, 0, 0, 0, 0));
    chk("reset_ovr", {31'b0, TREF_OVERRUN}, 32'd0);
    chk("reset_state", {30'b0, FSM_STATE}, 32'd0);
    step(); step();
    RST = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle", obs, mk(0, 0, 0, 0, 0, 0, 0));
    end

    // ---- single tick, full sweep 0..255
    TREF_TICK = 1'b1;
    step();
    TREF_TICK = 1'b0;
    chk("tick_busy", obs, mk(0, 0, 0, 0, 0, 1, 0));
    step();
    for (int i = 0; i < 256; i++) exp_upd("sweep1", 1, i, 1);
    chk("sweep1_end", obs, mk(0, 0, 0, 0, 0, 0, 255));

    // ---- events with no sweep, then a tick arriving mid-stream
    EVT_REQ = 1'b1; EVT_NEUR = 8'h2A;
    chk("evt_idle", obs, mk(0, 0, 0, 0, 0, 0, 255));
    step();
    for (int i = 0; i < 20; i++) exp_upd("evt_solo", 0, 'h2A, 0);
    TREF_TICK = 1'b1;
    chk("evt21_rd", obs, mk(1, 0, 0, 1, 0, 0, 'h2A));
    step();
    TREF_TICK = 1'b0;
    chk("evt21_wr", obs, mk(1, 1, 0, 1, 1, 1, 'h2A));
    step();
    // saturated run counter lets the sweep in first, then 4 events : 1 step
    for (int k = 0; k < 5; k++) begin
      exp_upd("mix_tref", 1, k, 1);
      for (int j = 0; j < 4; j++) exp_upd("mix_evt", 0, 'h2A, 1);
    end
    EVT_REQ = 1'b0;
    exp_upd("mix_tail", 1, 5, 1);
    exp_upd("mix_tail", 1, 6, 1);
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (!SWEEP_BUSY) begin found = 1'b1; break; end
      step();
    end
    chk("mix_done", {31'b0, found}, 32'd1);
    step();
    chk("mix_idle", obs, mk(0, 0, 0, 0, 0, 0, 255));

    // ---- three ticks in one sweep
    TREF_TICK = 1'b1;
    step();
    TREF_TICK = 1'b0;
    step(); step(); step();
    TREF_TICK = 1'b1;
    step();
    TREF_TICK = 1'b0;
    chk("ovr_after2", {31'b0, TREF_OVERRUN}, 32'd0);
    step();
    TREF_TICK = 1'b1;
    step();
    TREF_TICK = 1'b0;
    chk("ovr_after3", {31'b0, TREF_OVERRUN}, 32'd1);
    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (NEUR_WE && NEUR_ADDR == 8'd255) begin found = 1'b1; break; end
      step();
    end
    chk("sweepA_last", {31'b0, found}, 32'd1);
    step();
    chk("sweepB_start", obs, mk(1, 0, 1, 0, 0, 1, 0));
    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!SWEEP_BUSY) begin found = 1'b1; break; end
      step();
    end
    chk("sweepB_done", {31'b0, found}, 32'd1);
    for (int i = 0; i < 5; i++) step();
    chk("no_sweepC", obs, mk(0, 0, 0, 0, 0, 0, 255));
    chk("ovr_sticky", {31'b0, TREF_OVERRUN}, 32'd1);

    // ---- reset clears overrun; sweep with disabled neuron 5, reset at addr 100
    RST = 1'b1;
    #1;
    chk("rst2_outs", obs, mk(0, 0, 0, 0, 0, 0, 0));
    chk("rst2_ovr", {31'b0, TREF_OVERRUN}, 32'd0);
    step();
    RST = 1'b0;
    TREF_TICK = 1'b1;
    step();
    TREF_TICK = 1'b0;
    step();
    for (int i = 0; i < 5; i++) exp_upd("sw3", 1, i, 1);
    chk("sw3_rd5", obs, mk(1, 0, 1, 0, 0, 1, 5));
    step();
    NEUR_RDATA_MSB = 1'b1;
    #1;
`ifdef IZH_SCHED_SKIP_DISABLED_EN
    chk("skip_cs5", {31'b0, NEUR_CS}, 32'd0);
`else
    chk("noskip_cs5", {31'b0, NEUR_CS}, 32'd1);
`endif
    NEUR_RDATA_MSB = 1'b0;
    step();
    chk("sw3_rd6", obs, mk(1, 0, 1, 0, 0, 1, 6));
    TREF_TICK = 1'b1;
    step();
    TREF_TICK = 1'b0;
    chk("sw3_wr6", obs, mk(1, 1, 1, 0, 0, 1, 6));
    step();
    for (int i = 7; i < 100; i++) exp_upd("sw3", 1, i, 1);
    chk("sw3_rd100", obs, mk(1, 0, 1, 0, 0, 1, 100));
    step();
    chk("sw3_wr100", obs, mk(1, 1, 1, 0, 0, 1, 100));
    RST = 1'b1;
    #1;
    chk("rst_mid_wr", obs, mk(0, 0, 0, 0, 0, 0, 0));
    step();
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("post_rst_idle", obs, mk(0, 0, 0, 0, 0, 0, 0));
    end
    // pointer must restart at 0
    TREF_TICK = 1'b1;
    step();
    TREF_TICK = 1'b0;
    step();
    exp_upd("restart", 1, 0, 1);
    exp_upd("restart", 1, 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
